// File: rtl/div32by16_seq.sv
// Sequential 32/16 unsigned restoring divider for the DIV r/m16 path.
// All subtraction goes through the single alu16_addsub instance; the borrow flag steers each step.

module alu16_addsub (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] y,
    output logic        cf
);

    logic [16:0] sum;

    // With sub=1 the carry-out is inverted so cf reads as an x86-style borrow.
    assign sum = {1'b0, a} + {1'b0, b ^ {16{sub}}} + {16'b0, sub};
    assign y   = sum[15:0];
    assign cf  = sum[16] ^ sub;

endmodule

module div32by16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_err,
    output logic [15:0] quotient,
    output logic [15:0] remainder
);

    typedef enum logic [1:0] {StIdle, StCheck, StIter} state_e;

    state_e      state_q, state_d;
    logic [15:0] r_q, r_d;
    logic [15:0] q_q, q_d;
    logic [15:0] d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div_err_q, div_err_d;
    logic [15:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;

    logic [15:0] rs, qs, alu_a, diff;
    logic        msb, cf, accept;

    assign msb   = r_q[15];
    assign rs    = {r_q[14:0], q_q[15]};
    assign qs    = {q_q[14:0], 1'b0};
    assign alu_a = (state_q == StIter) ? rs : r_q;

    alu16_addsub u_alu (
        .a   (alu_a),
        .b   (d_q),
        .sub (1'b1),
        .y   (diff),
        .cf  (cf)
    );

    // The shifted-out msb makes this a 17-bit compare of {msb, rs} against d_q.
    assign accept = msb | ~cf;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_err_d   = div_err_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    r_d     = dividend[31:16];
                    q_d     = dividend[15:0];
                    d_d     = divisor;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!cf) begin
                    done_d    = 1'b1;
                    div_err_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end else begin
                    state_d = StIter;
                end
            end
            StIter: begin
                r_d   = accept ? diff : rs;
                q_d   = qs | {15'b0, accept};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    done_d      = 1'b1;
                    div_err_d   = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            r_q         <= 16'd0;
            q_q         <= 16'd0;
            d_q         <= 16'd0;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_err_q   <= 1'b0;
            quotient_q  <= 16'd0;
            remainder_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_err_q   <= div_err_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div_err   = div_err_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_div32by16_seq.sv
// Randomised scoreboard bench for div32by16_seq: expected results are queued at issue time
// and a monitor compares them whenever done pulses.

module tb_div32by16_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy, done, div_err;
    logic [15:0] quotient, remainder;

    div32by16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_err   (div_err),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [15:0] q;
        logic [15:0] r;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] model_q = 16'd0;
    logic [15:0] model_r = 16'd0;
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic; a quotient that does not fit 16 bits is #DE.
    task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs);
        int   n;
        exp_t e;
        logic [31:0] quo;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("issue_wait_timeout", 32'd1, 32'd0);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        if (dvs == 16'd0) begin
            e.err = 1'b1;
        end else begin
            quo   = dvd / {16'd0, dvs};
            e.err = (quo > 32'h0000_FFFF);
        end
        if (!e.err) begin
            quo     = dvd / {16'd0, dvs};
            model_q = quo[15:0];
            quo     = dvd % {16'd0, dvs};
            model_r = quo[15:0];
        end
        e.q   = model_q;
        e.r   = model_r;
        e.due = cyc + (e.err ? 2 : 18);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("wait_done_timeout", 32'd1, 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                chk("done_width", {31'd0, prev_done}, 32'd0);
                chk("busy_with_done", {31'd0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    chk("div_err", {31'd0, div_err}, {31'd0, e.err});
                    chk("quotient", {16'd0, quotient}, {16'd0, e.q});
                    chk("remainder", {16'd0, remainder}, {16'd0, e.r});
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    initial begin
        logic [15:0] dvs;
        logic [15:0] hi;
        int          n;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div_err", {31'd0, div_err}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h0001_86A0, 16'h0007);
        issue(32'hFFFE_0001, 16'hFFFF);
        issue(32'h1234_5678, 16'h0000);
        issue(32'h0007_0000, 16'h0007);
        issue(32'h0006_FFFF, 16'h0007);

        // start while busy must be ignored
        issue(32'h0000_0064, 16'h0009);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        dividend = 32'h0000_0FFF;
        divisor  = 16'h0002;
        @(negedge clk);
        start = 1'b0;

        // start in the done cycle is accepted
        wait_done();
        issue(32'h0000_ABCD, 16'h0010);
        wait_done();
        issue(32'h0003_0000, 16'h0002);

        // reset in the middle of an iteration run
        issue(32'h0001_2345, 16'h0100);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_div_err", {31'd0, div_err}, 32'd0);
        chk("midrst_quotient", {16'd0, quotient}, 32'd0);
        chk("midrst_remainder", {16'd0, remainder}, 32'd0);
        sb.delete();
        model_q = 16'd0;
        model_r = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(32'h0000_FFFF, 16'h0001);

        for (int i = 0; i < 30; i++) begin
            dvs = 16'($urandom_range(1, 65535));
            hi  = 16'($urandom_range(0, int'(dvs) - 1));
            issue({hi, 16'($urandom)}, dvs);
        end
        for (int i = 0; i < 4; i++) begin
            dvs = 16'($urandom_range(0, 255));
            hi  = 16'($urandom_range(int'(dvs), 65535));
            issue({hi, 16'($urandom)}, dvs);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
